// File: rtl/sd_dat_card_receiver.sv
// Card-side SD DAT write receiver: deserializes host data blocks into 32-bit words, checks the
// per-line CRC16, then answers with the CRC status token and holds DAT0 busy.
module sd_dat_card_receiver #(
    parameter int BLOCK_SIZE  = 512,
    parameter int BUSY_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        mode,
    input  logic        dat_width,
    input  logic [3:0]  dat_i,
    output logic [3:0]  dat_o,
    output logic        dat_oe,
    output logic [31:0] word_o,
    output logic        word_valid,
    output logic        block_ok,
    output logic        block_err,
    output logic [15:0] block_count,
    output logic        done
);
    localparam logic [15:0] LAST_BIT_1 = 16'(8 * BLOCK_SIZE - 1);
    localparam logic [15:0] LAST_NIB_4 = 16'(2 * BLOCK_SIZE - 1);
    localparam logic [15:0] LAST_BUSY  = 16'(BUSY_CYCLES - 1);
    localparam logic [15:0] CRC_POLY   = 16'h1021;

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_START, S_DATA, S_CRC, S_END, S_TURN, S_STATUS, S_BUSY, S_RELEASE
    } state_t;

    state_t           state;
    logic [15:0]      cnt;
    logic             mode_q;
    logic             wide_q;
    logic [30:0]      shift_word;
    logic [3:0][15:0] crc_calc;
    logic [3:0][15:0] crc_rx;
    logic [3:0]       status_sr;
    logic             dat0_q;

    logic        start_seen;
    logic        data_last;
    logic        word_last;
    logic        crc_ok;
    logic        end_ok;
    logic [31:0] next_word;

    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic bit_in);
        return {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_in) ? CRC_POLY : 16'h0000);
    endfunction

    // Only DAT0 carries the card's response; the upper lines stay released high.
    assign dat_o = {3'b111, dat0_q};

    // NOTE: every signal gets its default before any conditional update, so no latch is inferred.
    always_comb begin
        start_seen = wide_q ? (dat_i == 4'h0) : ~dat_i[0];
        data_last  = (cnt == (wide_q ? LAST_NIB_4 : LAST_BIT_1));
        word_last  = wide_q ? (cnt[2:0] == 3'd7) : (cnt[4:0] == 5'd31);
        next_word  = wide_q ? {shift_word[27:0], dat_i} : {shift_word, dat_i[0]};
        crc_ok     = (crc_calc[0] == crc_rx[0]);
        end_ok     = dat_i[0];
        if (wide_q) begin
            for (int k = 1; k < 4; k++) begin
                crc_ok = crc_ok & (crc_calc[k] == crc_rx[k]);
                end_ok = end_ok & dat_i[k];
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every branch reads pre-edge register values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            mode_q      <= 1'b0;
            wide_q      <= 1'b0;
            shift_word  <= '0;
            crc_calc    <= '0;
            crc_rx      <= '0;
            status_sr   <= '0;
            dat0_q      <= 1'b1;
            dat_oe      <= 1'b0;
            word_o      <= '0;
            word_valid  <= 1'b0;
            block_ok    <= 1'b0;
            block_err   <= 1'b0;
            block_count <= '0;
            done        <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            block_ok   <= 1'b0;
            block_err  <= 1'b0;
            done       <= 1'b0;
            case (state)
                S_IDLE: if (enable) begin
                    state       <= S_WAIT_START;
                    block_count <= '0;
                    mode_q      <= mode;
                    wide_q      <= dat_width;
                end
                S_WAIT_START:
                    if (!enable) state <= S_IDLE;
                    else if (start_seen) begin
                        state    <= S_DATA;
                        cnt      <= '0;
                        crc_calc <= '0;
                    end
                S_DATA:
                    if (!enable) state <= S_IDLE;
                    else begin
                        shift_word <= next_word[30:0];
                        for (int k = 0; k < 4; k++)
                            if (wide_q || k == 0) crc_calc[k] <= crc_step(crc_calc[k], dat_i[k]);
                        if (word_last) begin
                            word_o     <= next_word;
                            word_valid <= 1'b1;
                        end
                        cnt <= cnt + 16'd1;
                        if (data_last) begin
                            state <= S_CRC;
                            cnt   <= '0;
                        end
                    end
                S_CRC:
                    if (!enable) state <= S_IDLE;
                    else begin
                        for (int k = 0; k < 4; k++) crc_rx[k] <= {crc_rx[k][14:0], dat_i[k]};
                        cnt <= cnt + 16'd1;
                        if (cnt == 16'd15) state <= S_END;
                    end
                S_END:
                    if (!enable) state <= S_IDLE;
                    else begin
                        // Token bits after the start bit: {s2, s1, s0, end}.
                        if (crc_ok && end_ok) begin
                            block_ok  <= 1'b1;
                            status_sr <= 4'b0101;
                        end else begin
                            block_err <= 1'b1;
                            status_sr <= 4'b1011;
                        end
                        block_count <= block_count + 16'd1;
                        state       <= S_TURN;
                        cnt         <= '0;
                    end
                S_TURN:
                    if (!enable) state <= S_IDLE;
                    else if (cnt == 16'd1) begin
                        state  <= S_STATUS;
                        dat_oe <= 1'b1;
                        dat0_q <= 1'b0;
                        cnt    <= '0;
                    end else cnt <= cnt + 16'd1;
                S_STATUS:
                    if (cnt == 16'd4) begin
                        state  <= S_BUSY;
                        dat0_q <= 1'b0;
                        cnt    <= '0;
                    end else begin
                        dat0_q    <= status_sr[3];
                        status_sr <= {status_sr[2:0], 1'b0};
                        cnt       <= cnt + 16'd1;
                    end
                S_BUSY:
                    if (cnt == LAST_BUSY) begin
                        state  <= S_RELEASE;
                        dat0_q <= 1'b1;
                    end else cnt <= cnt + 16'd1;
                S_RELEASE: begin
                    dat_oe <= 1'b0;
                    dat0_q <= 1'b1;
                    if (mode_q && enable) state <= S_WAIT_START;
                    else begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_dat_card_receiver.sv
// Self-checking bench for sd_dat_card_receiver: random blocks, CRC by polynomial division,
// expected words, token and timing derived from the block format.
module tb_sd_dat_card_receiver;
    localparam int BS      = 8;
    localparam int BUSY    = 8;
    localparam int TOK_LEN = 5 + BUSY + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        mode = 1'b0;
    logic        dat_width = 1'b0;
    logic [3:0]  dat_i = 4'hF;
    logic [3:0]  dat_o;
    logic        dat_oe;
    logic [31:0] word_o;
    logic        word_valid;
    logic        block_ok;
    logic        block_err;
    logic [15:0] block_count;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int side_viol = 0;
    int side_base = 0;
    bit mon_en = 1'b0;

    logic [31:0] word_q[$];
    int          word_cyc_q[$];
    logic        blk_q[$];
    int          blk_cyc_q[$];
    logic        oe_q[$];
    int          oe_cyc_q[$];
    int          done_cyc_q[$];
    logic [7:0]  data_q[$];
    logic [3:0]  frame_q[$];
    logic [31:0] exp_words[$];

    sd_dat_card_receiver #(.BLOCK_SIZE(BS), .BUSY_CYCLES(BUSY)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .dat_width(dat_width),
        .dat_i(dat_i), .dat_o(dat_o), .dat_oe(dat_oe), .word_o(word_o), .word_valid(word_valid),
        .block_ok(block_ok), .block_err(block_err), .block_count(block_count), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder, sampled half a cycle after each active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (word_valid === 1'b1) begin word_q.push_back(word_o); word_cyc_q.push_back(cyc); end
            if (block_ok === 1'b1) begin blk_q.push_back(1'b1); blk_cyc_q.push_back(cyc); end
            if (block_err === 1'b1) begin blk_q.push_back(1'b0); blk_cyc_q.push_back(cyc); end
            if (dat_oe === 1'b1) begin oe_q.push_back(dat_o[0]); oe_cyc_q.push_back(cyc); end
            if (done === 1'b1) done_cyc_q.push_back(cyc);
            if (dat_o[3:1] !== 3'b111 || (dat_oe !== 1'b1 && dat_o[0] !== 1'b1))
                side_viol <= side_viol + 1;
        end
    end

    task automatic cycle(input logic [3:0] d);
        dat_i = d;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        word_q.delete(); word_cyc_q.delete(); blk_q.delete(); blk_cyc_q.delete();
        oe_q.delete(); oe_cyc_q.delete(); done_cyc_q.delete(); exp_words.delete();
        side_base = side_viol;
    endtask

    // CRC16 (x^16+x^12+x^5+1, init 0) as the remainder of msg(x)*x^16 divided by the generator.
    function automatic logic [15:0] crc16(input bit msg[$]);
        logic [16:0] g = 17'h11021;
        logic [15:0] rem;
        bit r[$];
        r = msg;
        repeat (16) r.push_back(1'b0);
        for (int i = 0; i < msg.size(); i++)
            if (r[i]) for (int j = 0; j < 17; j++) r[i+j] = r[i+j] ^ g[16-j];
        rem = '0;
        for (int j = 0; j < 16; j++) rem[15-j] = r[msg.size()+j];
        return rem;
    endfunction

    function automatic logic [63:0] exp_token(input bit ok);
        logic [63:0] v;
        v = ok ? 64'b00101 : 64'b01011;
        v = v << BUSY;
        return (v << 1) | 64'd1;
    endfunction

    function automatic logic [63:0] pack_oe();
        logic [63:0] v = '0;
        foreach (oe_q[i]) v = (v << 1) | 64'(oe_q[i]);
        return v;
    endfunction

    task automatic fill_random();
        data_q.delete();
        for (int i = 0; i < BS; i++) data_q.push_back(8'($urandom));
    endtask

    task automatic build_frame(input bit wide, input int flip_line, input int flip_bit, input logic end_bit);
        logic [15:0] crc_exp [4];
        bit line[$];
        frame_q.delete();
        for (int k = 0; k < 4; k++) begin
            line.delete();
            foreach (data_q[i]) begin
                if (wide) begin line.push_back(data_q[i][4+k]); line.push_back(data_q[i][k]); end
                else for (int b = 7; b >= 0; b--) line.push_back(data_q[i][b]);
            end
            crc_exp[k] = crc16(line);
        end
        if (flip_line >= 0) crc_exp[flip_line][flip_bit] = ~crc_exp[flip_line][flip_bit];
        frame_q.push_back(wide ? 4'h0 : 4'hE);
        foreach (data_q[i]) begin
            if (wide) begin frame_q.push_back(data_q[i][7:4]); frame_q.push_back(data_q[i][3:0]); end
            else for (int b = 7; b >= 0; b--) frame_q.push_back({3'b111, data_q[i][b]});
        end
        for (int j = 15; j >= 0; j--)
            frame_q.push_back(wide ? {crc_exp[3][j], crc_exp[2][j], crc_exp[1][j], crc_exp[0][j]}
                                   : {3'b111, crc_exp[0][j]});
        frame_q.push_back(wide ? {4{end_bit}} : {3'b111, end_bit});
        for (int w = 0; w < BS / 4; w++)
            exp_words.push_back({data_q[4*w], data_q[4*w+1], data_q[4*w+2], data_q[4*w+3]});
    endtask

    task automatic send_frame(output int start_edge);
        start_edge = cyc + 1;
        foreach (frame_q[i]) cycle(frame_q[i]);
        dat_i = 4'hF;
    endtask

    // Idle the bus until the card's DAT0 drive ends (or stop_at driven cycles); optionally drop enable.
    task automatic wait_oe(input int drop_at, input int stop_at);
        int n_oe = 0;
        for (int t = 0; t < 300; t++) begin
            cycle(4'hF);
            if (dat_oe === 1'b1) n_oe++;
            if (n_oe == drop_at) enable = 1'b0;
            if (n_oe > 0 && (n_oe == stop_at || dat_oe !== 1'b1)) return;
        end
        checks++; errors++;
        $display("FAIL wait_oe: card DAT0 drive not completed within 300 cycles (driven %0d)", n_oe);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) cycle(4'hF);
        checks++; if (dat_o !== 4'hF) begin errors++; $display("FAIL reset dat_o: got %h expected f", dat_o); end
        checks++; if (dat_oe !== 1'b0) begin errors++; $display("FAIL reset dat_oe: got %b expected 0", dat_oe); end
        checks++; if (word_o !== 32'h0) begin errors++; $display("FAIL reset word_o: got %h expected 0", word_o); end
        checks++; if ({word_valid, block_ok, block_err, done} !== 4'b0) begin
            errors++; $display("FAIL reset pulses: got %b expected 0000", {word_valid, block_ok, block_err, done}); end
        checks++; if (block_count !== 16'h0) begin errors++; $display("FAIL reset block_count: got %0d expected 0", block_count); end
        reset = 1'b0;
        cycle(4'hF);
    endtask

    task automatic test_single_block(input string name, input bit wide, input bit fixed_data,
                                     input int flip_line, input logic end_bit);
        int s;
        int n;
        bit exp_ok;
        exp_ok = (flip_line < 0) && (end_bit === 1'b1);
        n = wide ? 2 * BS : 8 * BS;
        if (fixed_data) begin
            data_q.delete();
            for (int i = 0; i < BS; i++) data_q.push_back(8'(i + 1));
        end else fill_random();
        mode = 1'b0; dat_width = wide; enable = 1'b1;
        cycle(4'hF); cycle(4'hF);
        clear_mon();
        build_frame(wide, flip_line, int'($urandom_range(0, 15)), end_bit);
        send_frame(s);
        wait_oe(8, -1);
        cycle(4'hF); cycle(4'hF);
        checks++; if (word_q.size() != BS / 4) begin
            errors++; $display("FAIL %s word count: got %0d expected %0d", name, word_q.size(), BS / 4); end
        foreach (exp_words[i]) begin
            checks++;
            if (word_q.size() <= i || word_q[i] !== exp_words[i]) begin
                errors++; $display("FAIL %s word %0d: got %h expected %h", name, i, word_q[i], exp_words[i]); end
        end
        checks++; if (word_cyc_q.size() == 0 || word_cyc_q[0] - s != (wide ? 8 : 32)) begin
            errors++; $display("FAIL %s first word latency: got %0d expected %0d", name,
                               word_cyc_q.size() ? word_cyc_q[0] - s : -1, wide ? 8 : 32); end
        checks++; if (blk_q.size() != 1 || blk_q[0] !== exp_ok) begin
            errors++; $display("FAIL %s block result: got %0d pulses first=%b expected 1 pulse ok=%b",
                               name, blk_q.size(), blk_q.size() ? blk_q[0] : 1'bx, exp_ok); end
        checks++; if (blk_cyc_q.size() == 0 || blk_cyc_q[0] != s + n + 17) begin
            errors++; $display("FAIL %s block pulse cycle: got %0d expected %0d", name,
                               blk_cyc_q.size() ? blk_cyc_q[0] : -1, s + n + 17); end
        checks++; if (oe_cyc_q.size() == 0 || oe_cyc_q[0] != s + n + 19) begin
            errors++; $display("FAIL %s status start cycle: got %0d expected %0d", name,
                               oe_cyc_q.size() ? oe_cyc_q[0] : -1, s + n + 19); end
        checks++; if (oe_q.size() != TOK_LEN || pack_oe() !== exp_token(exp_ok)) begin
            errors++; $display("FAIL %s DAT0 token+busy: got %0d bits %h expected %0d bits %h",
                               name, oe_q.size(), pack_oe(), TOK_LEN, exp_token(exp_ok)); end
        checks++; if (done_cyc_q.size() != 1 || oe_cyc_q.size() == 0 || done_cyc_q[0] != oe_cyc_q[$] + 1) begin
            errors++; $display("FAIL %s done: got %0d pulses expected 1 right after release", name, done_cyc_q.size()); end
        checks++; if (block_count !== 16'd1) begin
            errors++; $display("FAIL %s block_count: got %0d expected 1", name, block_count); end
        checks++; if (side_viol != side_base) begin
            errors++; $display("FAIL %s idle-high DAT lines: got %0d bad cycles expected 0", name, side_viol - side_base); end
    endtask

    task automatic test_multi_block();
        int s;
        int n_ok = 0;
        bit wide;
        logic [63:0] exp3;
        wide = 1'($urandom_range(0, 1));
        mode = 1'b1; dat_width = wide; enable = 1'b1;
        cycle(4'hF); cycle(4'hF);
        clear_mon();
        for (int b = 0; b < 3; b++) begin
            fill_random();
            build_frame(wide, -1, 0, 1'b1);
            send_frame(s);
            wait_oe(b == 2 ? 8 : -1, -1);
        end
        mode = 1'b0;
        cycle(4'hF); cycle(4'hF);
        exp3 = (exp_token(1'b1) << (2 * TOK_LEN)) | (exp_token(1'b1) << TOK_LEN) | exp_token(1'b1);
        checks++; if (word_q.size() != 3 * BS / 4) begin
            errors++; $display("FAIL multi word count: got %0d expected %0d", word_q.size(), 3 * BS / 4); end
        foreach (exp_words[i]) begin
            checks++;
            if (word_q.size() <= i || word_q[i] !== exp_words[i]) begin
                errors++; $display("FAIL multi word %0d: got %h expected %h", i, word_q[i], exp_words[i]); end
        end
        foreach (blk_q[i]) if (blk_q[i] === 1'b1) n_ok++;
        checks++; if (blk_q.size() != 3 || n_ok != 3) begin
            errors++; $display("FAIL multi block_ok: got %0d pulses %0d ok expected 3 ok", blk_q.size(), n_ok); end
        checks++; if (block_count !== 16'd3) begin
            errors++; $display("FAIL multi block_count: got %0d expected 3", block_count); end
        checks++; if (oe_q.size() != 3 * TOK_LEN || pack_oe() !== exp3) begin
            errors++; $display("FAIL multi DAT0 tokens: got %0d bits %h expected %0d bits %h",
                               oe_q.size(), pack_oe(), 3 * TOK_LEN, exp3); end
        checks++; if (done_cyc_q.size() != 1 || oe_cyc_q.size() == 0 || done_cyc_q[0] != oe_cyc_q[$] + 1) begin
            errors++; $display("FAIL multi done: got %0d pulses expected 1 after final release", done_cyc_q.size()); end
    endtask

    task automatic test_abort_enable();
        int s;
        mode = 1'b0; dat_width = 1'b0; enable = 1'b1;
        cycle(4'hF); cycle(4'hF);
        clear_mon();
        fill_random();
        build_frame(1'b0, -1, 0, 1'b1);
        for (int i = 0; i < 21; i++) cycle(frame_q[i]);
        enable = 1'b0;
        cycle(frame_q[21]);
        checks++; if (dat_oe !== 1'b0) begin errors++; $display("FAIL abort dat_oe: got %b expected 0", dat_oe); end
        repeat (120) cycle(4'hF);
        checks++; if (word_q.size() + blk_q.size() != 0) begin
            errors++; $display("FAIL abort outputs: got %0d words %0d block pulses expected 0", word_q.size(), blk_q.size()); end
        checks++; if (oe_q.size() != 0) begin errors++; $display("FAIL abort DAT0 drive: got %0d cycles expected 0", oe_q.size()); end
        checks++; if (done_cyc_q.size() != 0) begin errors++; $display("FAIL abort done: got %0d pulses expected 0", done_cyc_q.size()); end
        enable = 1'b1;
        cycle(4'hF); cycle(4'hF);
        checks++; if (block_count !== 16'd0) begin errors++; $display("FAIL abort recount: got %0d expected 0", block_count); end
        clear_mon();
        fill_random();
        build_frame(1'b0, -1, 0, 1'b1);
        send_frame(s);
        wait_oe(8, -1);
        cycle(4'hF);
        checks++; if (blk_q.size() != 1 || blk_q[0] !== 1'b1 || block_count !== 16'd1) begin
            errors++; $display("FAIL abort recovery: got %0d pulses count %0d expected 1 ok count 1", blk_q.size(), block_count); end
    endtask

    task automatic test_reset_busy();
        int s;
        bit wide;
        wide = 1'($urandom_range(0, 1));
        mode = 1'b0; dat_width = wide; enable = 1'b1;
        cycle(4'hF); cycle(4'hF);
        clear_mon();
        fill_random();
        build_frame(wide, -1, 0, 1'b1);
        send_frame(s);
        wait_oe(-1, 8);
        reset = 1'b1;
        cycle(4'hF);
        checks++; if (dat_oe !== 1'b0 || dat_o !== 4'hF) begin
            errors++; $display("FAIL reset_busy DAT: got oe=%b dat_o=%h expected oe=0 dat_o=f", dat_oe, dat_o); end
        checks++; if (word_o !== 32'h0 || block_count !== 16'h0) begin
            errors++; $display("FAIL reset_busy regs: got word=%h count=%0d expected 0 0", word_o, block_count); end
        checks++; if ({word_valid, block_ok, block_err, done} !== 4'b0) begin
            errors++; $display("FAIL reset_busy pulses: got %b expected 0000", {word_valid, block_ok, block_err, done}); end
        enable = 1'b0;
        reset = 1'b0;
        clear_mon();
        repeat (30) cycle(4'hF);
        checks++; if (oe_q.size() != 0 || done_cyc_q.size() != 0) begin
            errors++; $display("FAIL reset_busy aftermath: got %0d drive cycles %0d done expected 0 0", oe_q.size(), done_cyc_q.size()); end
    endtask

    initial begin
        test_reset();
        mon_en = 1'b1;
        test_single_block("single_1bit", 1'b0, 1'b1, -1, 1'b1);
        test_single_block("single_4bit", 1'b1, 1'b1, -1, 1'b1);
        test_single_block("random_1bit", 1'b0, 1'b0, -1, 1'b1);
        test_single_block("random_4bit", 1'b1, 1'b0, -1, 1'b1);
        test_single_block("crc_err_dat2", 1'b1, 1'b0, 2, 1'b1);
        test_single_block("end_bit_1bit", 1'b0, 1'b0, -1, 1'b0);
        test_single_block("end_bit_4bit", 1'b1, 1'b0, -1, 1'b0);
        test_multi_block();
        test_abort_enable();
        test_reset_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sd_dat_card_receiver.md
Name: sd_dat_card_receiver

Overview:
- Card-side end of the SD DAT write path: receives data blocks the host drives onto DAT[3:0], deserializes them into 32-bit words and checks the per-line CRC16.
- Returns the SD CRC status token, then signals busy on DAT0.
- Serves as the protocol counterpart and bench partner of the host DAT communication block. Supports 1-bit/4-bit width and single/multi-block transfers.

Parameters:
BLOCK_SIZE, 512, block length in bytes; multiple of 4, range 4..2048
BUSY_CYCLES, 8, cycles DAT0 is held low after the status token (>=1)

Ports:
clk  in  1  system clock; all DAT bits are sampled and driven on its rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  transfer window; low aborts
mode  in  1  1 = multi-block, 0 = single block
dat_width  in  1  1 = 4-bit bus, 0 = 1-bit (DAT0 only)
dat_i  in  4  DAT lines from host (idle high)
dat_o  out  4  DAT value driven by card (only dat_o[0] used)
dat_oe  out  1  card drives DAT0 when 1
word_o  out  32  received word; first byte in [31:24]
word_valid  out  1  1-cycle pulse, word_o valid
block_ok  out  1  1-cycle pulse, block passed CRC and end bit
block_err  out  1  1-cycle pulse, block failed CRC or end bit
block_count  out  16  blocks received since leaving IDLE (ok or err); wraps at 16'hFFFF->0
done  out  1  1-cycle pulse, transfer complete (single-block end or busy release after enable low)

Behaviour:
- Reset: state IDLE; dat_o=4'hF, dat_oe=0, word_o=0, all pulses 0, block_count=0, CRC registers 0.
- mode and dat_width are latched on the IDLE->WAIT_START edge. They are ignored after that.
- States and transitions:
  - IDLE: enable=1 -> WAIT_START, block_count cleared.
  - WAIT_START: start is dat_i[0]=0 (1-bit) or dat_i=4'h0 (4-bit) -> DATA. In 4-bit mode a partial-zero pattern is ignored.
  - DATA: 1-bit mode takes 8*BLOCK_SIZE bits on DAT0, MSB first. 4-bit mode takes 2*BLOCK_SIZE nibbles, with dat_i[3] carrying bit 7 then bit 3.
  - Each completed 32-bit word: word_o updated and word_valid pulsed the cycle after its last bit is sampled.
  - CRC: 16 cycles; per active line, the received CRC is shifted MSB first.
  - CRC16 poly x^16+x^12+x^5+1, init 0, computed per line over that line's data bits only. 1-bit mode checks line 0 only.
  - END: sample end bit on active lines; all must be 1. Next cycle pulse block_ok or block_err and increment block_count.
  - TURN: 2 cycles, dat_oe=0.
  - STATUS: dat_oe=1, drive 5 bits on dat_o[0]: 0, s2, s1, s0, 1. Status bits are 010 when ok, 101 when err.
  - BUSY: dat_o[0]=0 for BUSY_CYCLES.
  - RELEASE: dat_o[0]=1 for 1 cycle, then dat_oe=0.
  - Exit from RELEASE: if mode=1 and enable=1 -> WAIT_START. Otherwise pulse done and go to IDLE.
- dat_o[3:1] are always 1. dat_o[0] is 1 whenever dat_oe=0.
- A block with an error is still counted. Its words have already been emitted; the consumer discards them using block_err.
- enable low in WAIT_START/DATA/CRC/END/TURN: next edge -> IDLE, dat_oe=0, no done, no block pulse.
- enable low in STATUS/BUSY: the token or busy completes, then RELEASE -> done -> IDLE.
- A second start bit during STATUS/BUSY is ignored.
- reset mid-operation: all state returns to reset values at the next edge.
- Latency from start-bit sample to first word_valid: 32 cycles (1-bit) or 8 cycles (4-bit).

Test Plan:
- BLOCK_SIZE=8, 1-bit, single block, data 0x01..0x08 with correct CRC -> word_valid pulses with 0x01020304 then 0x05060708; block_ok; token 0,0,1,0,1 on DAT0; DAT0 low 8 cycles, high 1 cycle; done; block_count=1.
- Same data in 4-bit mode -> the same two words, the first one 8 cycles after start; block_ok.
- Flip one CRC bit on DAT2 in 4-bit mode -> block_err; token 0,1,0,1,1; busy still issued.
- Multi-block, 3 blocks with enable held high, then enable dropped during the third block's busy -> block_ok x3, block_count=3, done after RELEASE.
- End bit 0 with correct CRC -> block_err.
- enable dropped mid-DATA, and separately reset asserted mid-BUSY -> IDLE; dat_oe=0; no done on enable abort; outputs at reset values after reset.
